// File: rtl/pipe_pkg.sv
// pipe_pkg: shared FSM encoding and parameter defaults for the pipeline controller
package pipe_pkg;
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ILLEGAL  = 2'd3
  } state_t;
  localparam int REG_W_DEF       = 6;
  localparam int PC_W_DEF        = 12;
  localparam int MEM_TIMEOUT_DEF = 15;
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 2);
  endfunction
endpackage

// File: rtl/pipe_ctrl_hazard.sv
// hazard_detect: flags a load in EX whose destination feeds an operand of the instruction in ID
module hazard_detect
  import pipe_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  output logic             hazard
);
  always_comb
    hazard = ex_memrd && (ex_wr_reg != '0) &&
             ((ex_wr_reg == id_rs1) || (id_uses_rs2 && (ex_wr_reg == id_rs2)));
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush/redirect control for a 5-stage pipeline with a data-memory handshake.
// Define PIPE_CTRL_PERF_EN to add saturating stall_cnt / flush_cnt performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int PC_W        = PC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs2,
  input  logic             ex_memrd,
  input  logic [REG_W-1:0] ex_wr_reg,
  input  logic             em_branch,
  input  logic             em_zero,
  input  logic [PC_W-1:0]  em_pc_out,
  input  logic             em_memrd,
  input  logic             em_memwr,
  output logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             idex_stall,
  output logic             exmem_stall,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             pc_redirect,
  output logic [PC_W-1:0]  pc_target,
  output logic             dmem_err,
`ifdef PIPE_CTRL_PERF_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt,
`endif
  output logic [1:0]       state
);
  localparam int CW = cnt_width(MEM_TIMEOUT);
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            hazard, mem, taken;
  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .ex_memrd    (ex_memrd),
    .ex_wr_reg   (ex_wr_reg),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .hazard      (hazard)
  );
  assign mem   = em_memrd | em_memwr;
  assign taken = em_branch & em_zero & ~mem;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    dmem_req    = 1'b0;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_stall  = 1'b0;
    exmem_stall = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    case (state_q)
      RUN: begin
        dmem_req = mem;
        if (mem && !dmem_ack) begin
          state_d     = MEM_WAIT;
          cnt_d       = CW'(1);
          {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'hf;
          memwb_flush = 1'b1;
        end else if (taken) begin
          state_d     = FLUSH;
          pc_redirect = 1'b1;
          pc_target   = em_pc_out;
          {ifid_flush, idex_flush, exmem_flush} = 3'b111;
        end else if (hazard) begin
          {pc_stall, ifid_stall, idex_flush} = 3'b111;
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        cnt_d    = cnt_q + CW'(cnt_q != '1);
        if (dmem_ack) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          {pc_stall, ifid_stall, idex_stall} = 3'b111;
          memwb_flush = 1'b1;
          // on timeout the access is dropped from EX/MEM rather than held
          if (cnt_q >= CW'(MEM_TIMEOUT)) begin
            state_d     = RUN;
            cnt_d       = '0;
            err_d       = 1'b1;
            exmem_flush = 1'b1;
          end else begin
            exmem_stall = 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      dmem_req    = 1'b0;
      {pc_stall, ifid_stall, idex_stall, exmem_stall} = 4'h0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'hf;
      pc_redirect = 1'b0;
      pc_target   = '0;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + 16'(pc_stall && (stall_cnt_q != '1));
    flush_cnt_d = flush_cnt_q + 16'(pc_redirect && (flush_cnt_q != '1));
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      err_q       <= 1'b0;
`ifdef PIPE_CTRL_PERF_EN
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`ifdef PIPE_CTRL_PERF_EN
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
`endif
    end
  end
  assign dmem_err = err_q;
  assign state    = state_q;
endmodule
